// File: rtl/flash_read_sched.sv
// -----------------------------------------------------------------------------
// flash_read_sched
//
// Shares one SPI flash (mode 0, single I/O) between two requesters. Each
// granted request runs a standard read: opcode 0x03, a 24-bit address and
// 32 data bits, all MSB first. The four received bytes are packed
// little-endian into rdata, so the first byte lands in rdata[7:0].
// Ties between requesters are broken round-robin.
//
// Ports
//   wb_clk_i   in   1   clock, rising edge
//   wb_rst_i   in   1   synchronous active-high reset
//   req_valid  in   2   read request, bit i = requester i
//   req0_addr  in  24   requester 0 byte address
//   req1_addr  in  24   requester 1 byte address
//   req_ready  out  2   one-cycle grant pulse
//   req_done   out  2   one-cycle completion pulse to the owner
//   rdata      out 32   read word, valid from req_done until the next one
//   flash_csb  out  1   SPI chip select, active low
//   flash_clk  out  1   SPI clock, idles low
//   flash_io0  out  1   SPI MOSI
//   flash_io1  in   1   SPI MISO
//
// State  | meaning
// S_IDLE | waiting for a request; grant issued combinationally here
// S_CMD  | shifting out the 8-bit opcode
// S_ADDR | shifting out the 24-bit address
// S_DATA | shifting in 32 data bits, MOSI held low
// S_GAP  | chip select high for 2 cycles; req_done in the first one
// -----------------------------------------------------------------------------
module flash_read_sched #(
  parameter int CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_valid,
  input  logic [23:0] req0_addr,
  input  logic [23:0] req1_addr,
  output logic [1:0]  req_ready,
  output logic [1:0]  req_done,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_GAP
  } state_t;

  // Per-bit down-counter: upper half of the count is the low phase,
  // lower half the high phase. Terminal count 0 ends the bit.
  localparam logic [8:0] TICK_LOAD   = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] TICK_RISE   = 9'(CLK_DIV - 1);
  localparam logic [8:0] TICK_HIGH   = 9'(CLK_DIV);
  localparam logic [7:0] OPCODE_READ = 8'h03;

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_tick;
  logic [5:0]  r_bit_cnt;
  logic [63:0] r_shift;
  logic [31:0] r_rx;
  logic [31:0] r_rdata;
  logic        r_owner;     // also the round-robin pointer: last requester granted
  logic        r_gap_cnt;

  logic        w_busy;
  logic        w_bit_end;
  logic        w_rise;
  logic        w_last_bit;
  logic        w_grant_idx;
  logic [1:0]  w_grant_vec;
  logic [31:0] w_rx_next;

  always_comb begin
    w_state_next = r_state;
    w_grant_idx  = 1'b0;
    w_grant_vec  = 2'b00;
    w_busy       = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    w_bit_end    = w_busy && (r_tick == 9'd0);
    w_rise       = w_busy && (r_tick == TICK_RISE);
    w_last_bit   = (r_state == S_DATA) && w_bit_end && (r_bit_cnt == 6'd0);
    // The final data bit is sampled in the same cycle the word is committed,
    // so rdata is built from the post-sample value.
    w_rx_next    = (w_rise && (r_state == S_DATA)) ? {r_rx[30:0], flash_io1} : r_rx;

    case (r_state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          w_grant_idx  = (req_valid == 2'b11) ? ~r_owner : req_valid[1];
          w_grant_vec  = w_grant_idx ? 2'b10 : 2'b01;
          w_state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (w_bit_end && (r_bit_cnt == 6'd56)) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_bit_end && (r_bit_cnt == 6'd32)) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_last_bit) w_state_next = S_GAP;
      end
      S_GAP: begin
        if (!r_gap_cnt) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_tick    <= 9'd0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 64'd0;
      r_rx      <= 32'd0;
      r_rdata   <= 32'd0;
      r_owner   <= 1'b1;   // pretend requester 1 went last so a tie favours 0
      r_gap_cnt <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rx    <= w_rx_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            r_owner   <= w_grant_idx;
            r_shift   <= {OPCODE_READ, (w_grant_idx ? req1_addr : req0_addr), 32'd0};
            r_tick    <= TICK_LOAD;
            r_bit_cnt <= 6'd63;
            r_rx      <= 32'd0;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (w_bit_end) begin
            r_tick <= TICK_LOAD;
            // Zeros shift in behind the address, so MOSI is 0 during DATA.
            r_shift <= {r_shift[62:0], 1'b0};
            if (w_last_bit) begin
              r_rdata   <= {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};
              r_gap_cnt <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt - 6'd1;
            end
          end else begin
            r_tick <= r_tick - 9'd1;
          end
        end
        S_GAP: begin
          r_gap_cnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = wb_rst_i ? 2'b00 : w_grant_vec;
  assign req_done  = ((r_state == S_GAP) && r_gap_cnt) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rdata     = r_rdata;
  assign flash_csb = ~w_busy;
  assign flash_clk = w_busy && (r_tick < TICK_HIGH);
  assign flash_io0 = w_busy && r_shift[63];

endmodule

// File: tb/tb_flash_read_sched.sv
module tb_flash_read_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT A: CLK_DIV=2
  logic [1:0]  a_valid, a_ready, a_done;
  logic [23:0] a_addr0, a_addr1;
  logic [31:0] a_rdata;
  logic        a_csb, a_clk, a_io0;
  logic        a_io1 = 1'b0;

  // DUT B: CLK_DIV=1
  logic [1:0]  b_valid, b_ready, b_done;
  logic [23:0] b_addr0, b_addr1;
  logic [31:0] b_rdata;
  logic        b_csb, b_clk, b_io0;
  logic        b_io1 = 1'b0;

  flash_read_sched #(.CLK_DIV(2)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(a_valid),
    .req0_addr(a_addr0), .req1_addr(a_addr1), .req_ready(a_ready),
    .req_done(a_done), .rdata(a_rdata), .flash_csb(a_csb),
    .flash_clk(a_clk), .flash_io0(a_io0), .flash_io1(a_io1)
  );

  flash_read_sched #(.CLK_DIV(1)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(b_valid),
    .req0_addr(b_addr0), .req1_addr(b_addr1), .req_ready(b_ready),
    .req_done(b_done), .rdata(b_rdata), .flash_csb(b_csb),
    .flash_clk(b_clk), .flash_io0(b_io0), .flash_io1(b_io1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash models and protocol monitors, sampled half a cycle from the active edge.
  logic [31:0] a_data = 32'd0, b_data = 32'd0;
  logic [31:0] a_cap = 32'd0, b_cap = 32'd0;
  int a_rise = 0, b_rise = 0;
  logic a_csb_q = 1'b1, a_clk_q = 1'b0, a_io0_q = 1'b0;
  logic b_csb_q = 1'b1, b_clk_q = 1'b0, b_io0_q = 1'b0;
  int a_viol = 0, b_viol = 0;
  int a_done0 = 0, a_done1 = 0;
  int b_last_rise = -1, b_period = 0;

  always @(negedge clk) begin
    if (a_ready == 2'b11 || a_done == 2'b11 || (a_ready != 2'b00 && a_done != 2'b00)) a_viol++;
    if (a_io0 !== a_io0_q && a_clk === 1'b1) a_viol++;
    if (!a_csb && a_rise >= 33 && a_io0 === 1'b1) a_viol++;
    if (a_done[0] === 1'b1) a_done0++;
    if (a_done[1] === 1'b1) a_done1++;
    if (a_csb_q && a_csb === 1'b0) begin a_rise = 0; a_cap = 32'd0; end
    if (!a_clk_q && a_clk === 1'b1) begin
      if (a_rise < 32) a_cap = {a_cap[30:0], a_io0};
      a_rise++;
    end
    if (a_clk_q && a_clk === 1'b0 && a_rise >= 32 && a_rise < 64) a_io1 = a_data[63 - a_rise];
    a_csb_q = a_csb; a_clk_q = a_clk; a_io0_q = a_io0;
  end

  always @(negedge clk) begin
    if (b_ready == 2'b11 || b_done == 2'b11 || (b_ready != 2'b00 && b_done != 2'b00)) b_viol++;
    if (b_io0 !== b_io0_q && b_clk === 1'b1) b_viol++;
    if (!b_csb && b_rise >= 33 && b_io0 === 1'b1) b_viol++;
    if (b_csb_q && b_csb === 1'b0) begin b_rise = 0; b_cap = 32'd0; end
    if (!b_clk_q && b_clk === 1'b1) begin
      if (b_rise < 32) b_cap = {b_cap[30:0], b_io0};
      b_rise++;
      if (b_last_rise >= 0) b_period = cyc - b_last_rise;
      b_last_rise = cyc;
    end
    if (b_clk_q && b_clk === 1'b0 && b_rise >= 32 && b_rise < 64) b_io1 = b_data[63 - b_rise];
    b_csb_q = b_csb; b_clk_q = b_clk; b_io0_q = b_io0;
  end

  task automatic wait_ready(input bit sel, output logic [1:0] vec, output int c);
    int n = 0;
    #1;
    vec = sel ? b_ready : a_ready;
    while (vec == 2'b00 && n < 600) begin
      @(negedge clk); #1;
      vec = sel ? b_ready : a_ready;
      n++;
    end
    c = cyc;
    chk("ready_seen", 64'(vec != 2'b00), 64'd1);
  endtask

  task automatic wait_done(input bit sel, output logic [1:0] vec, output int c);
    int n = 0;
    vec = 2'b00;
    while (vec == 2'b00 && n < 600) begin
      @(negedge clk); #1;
      vec = sel ? b_done : a_done;
      n++;
    end
    c = cyc;
    chk("done_seen", 64'(vec != 2'b00), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 2'b00; b_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] v, v2;
    int c0, c1, hi, n, d0;
    a_valid = 2'b00; b_valid = 2'b00;
    a_addr0 = 24'd0; a_addr1 = 24'd0; b_addr0 = 24'd0; b_addr1 = 24'd0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_done",  64'(a_done),  64'd0);
    chk("rst_rdata", 64'(a_rdata), 64'd0);
    chk("rst_csb",   64'(a_csb),   64'd1);
    chk("rst_fclk",  64'(a_clk),   64'd0);
    chk("rst_io0",   64'(a_io0),   64'd0);
    rst = 1'b0;

    // CLK_DIV=1, single request from requester 1
    b_data = 32'hCAFE0001; b_addr1 = 24'hABCDEF; b_valid = 2'b10;
    wait_ready(1'b1, v, c0);
    chk("b_grant", 64'(v), 64'h2);
    @(posedge clk); #1 b_valid = 2'b00;
    wait_done(1'b1, v, c1);
    chk("b_done",    64'(v), 64'h2);
    chk("b_latency", 64'(c1 - c0), 64'd129);
    chk("b_rdata",   64'(b_rdata), 64'h0100FECA);
    chk("b_cmdaddr", 64'(b_cap), 64'h03ABCDEF);
    chk("b_period",  64'(b_period), 64'd2);

    // Basic read, CLK_DIV=2
    do_reset();
    a_data = 32'hEFBEADDE; a_addr0 = 24'h000100; a_valid = 2'b01;
    wait_ready(1'b0, v, c0);
    chk("t1_grant", 64'(v), 64'h1);
    @(posedge clk); #1 a_valid = 2'b00;
    wait_done(1'b0, v, c1);
    chk("t1_done",    64'(v), 64'h1);
    chk("t1_latency", 64'(c1 - c0), 64'd257);
    chk("t1_rdata",   64'(a_rdata), 64'hDEADBEEF);
    chk("t1_cmdaddr", 64'(a_cap), 64'h03000100);

    // Tie in the first cycle after reset
    do_reset();
    a_addr1 = 24'h000200; a_valid = 2'b11;
    wait_ready(1'b0, v, c0);
    chk("t2_grant0", 64'(v), 64'h1);
    @(posedge clk); #1 a_valid = 2'b10;
    wait_done(1'b0, v, c1);
    chk("t2_done0", 64'(v), 64'h1);
    hi = 1; v2 = 2'b00; n = 0;
    while (a_csb === 1'b1 && n < 20) begin
      @(negedge clk); #1;
      if (a_ready != 2'b00) v2 = a_ready;
      if (a_csb === 1'b1) hi++;
      n++;
    end
    a_valid = 2'b00;
    chk("t2_csb_gap", 64'(hi >= 2), 64'd1);
    chk("t2_grant1",  64'(v2), 64'h2);
    wait_done(1'b0, v, c1);
    chk("t2_done1",    64'(v), 64'h2);
    chk("t2_cmdaddr1", 64'(a_cap), 64'h03000200);

    // Both held for four transactions: 0,1,0,1
    do_reset();
    a_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1'b0, v, c0);
      chk("t3_grant", 64'(v), (i % 2 == 1) ? 64'h2 : 64'h1);
      wait_done(1'b0, v, c1);
      chk("t3_done", 64'(v), (i % 2 == 1) ? 64'h2 : 64'h1);
    end
    a_valid = 2'b00;

    // Reset during ADDR, then a requester-1 read
    do_reset();
    a_addr0 = 24'h000100; a_valid = 2'b01;
    wait_ready(1'b0, v, c0);
    @(posedge clk); #1 a_valid = 2'b00;
    repeat (50) @(negedge clk);
    chk("t4_busy", 64'(a_csb), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_csb",   64'(a_csb), 64'd1);
    chk("t4_fclk",  64'(a_clk), 64'd0);
    chk("t4_done",  64'(a_done), 64'd0);
    chk("t4_rdata", 64'(a_rdata), 64'd0);
    d0 = a_done0;
    a_addr1 = 24'h00ABCD; a_data = 32'h5A5AA5A5; a_valid = 2'b10;
    wait_ready(1'b0, v, c0);
    chk("t4_grant1", 64'(v), 64'h2);
    @(posedge clk); #1 a_valid = 2'b00;
    wait_done(1'b0, v, c1);
    chk("t4_done1",    64'(v), 64'h2);
    chk("t4_latency",  64'(c1 - c0), 64'd257);
    chk("t4_cmdaddr",  64'(a_cap), 64'h0300ABCD);
    chk("t4_rdata1",   64'(a_rdata), 64'hA5A55A5A);
    chk("t4_no_done0", 64'(a_done0), 64'(d0));

    // Inputs changed mid-DATA are ignored
    a_data = 32'h11223344; a_addr0 = 24'h123456; a_valid = 2'b01;
    wait_ready(1'b0, v, c0);
    chk("t5_grant", 64'(v), 64'h1);
    d0 = a_done0;
    repeat (150) @(negedge clk);
    a_valid = 2'b00; a_addr0 = 24'hFFFFFF;
    wait_done(1'b0, v, c1);
    chk("t5_done",    64'(v), 64'h1);
    chk("t5_latency", 64'(c1 - c0), 64'd257);
    chk("t5_cmdaddr", 64'(a_cap), 64'h03123456);
    chk("t5_rdata",   64'(a_rdata), 64'h44332211);
    repeat (300) @(negedge clk);
    chk("t5_one_done", 64'(a_done0), 64'(d0 + 1));

    chk("a_protocol", 64'(a_viol), 64'd0);
    chk("b_protocol", 64'(b_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_read_sched.md
FLASH_READ_SCHED -- requirements
Module: flash_read_sched

Interface
REQ-001 Parameter CLK_DIV, default 2: SPI half-period in wb_clk_i cycles; legal range 1..255.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  2  per-requester read request; bit i belongs to requester i.
REQ-005 req0_addr  input  24  requester 0 flash byte address.
REQ-006 req1_addr  input  24  requester 1 flash byte address.
REQ-007 req_ready  output  2  one-cycle grant pulse; request i accepted when req_ready[i]=1.
REQ-008 req_done  output  2  one-cycle completion pulse to the owning requester.
REQ-009 rdata  output  32  read word; valid in the req_done cycle, held until the next req_done.
REQ-010 flash_csb  output  1  SPI chip select, active-low.
REQ-011 flash_clk  output  1  SPI clock, idles low (mode 0).
REQ-012 flash_io0  output  1  SPI MOSI.
REQ-013 flash_io1  input  1  SPI MISO.

Function
REQ-014 The block SHALL share one SPI flash between two requesters, executing a standard read (opcode 0x03) of 4 bytes per request.
REQ-015 FSM states SHALL be: IDLE, CMD (8 bits), ADDR (24 bits), DATA (32 bits), GAP.
REQ-016 IDLE: when any req_valid bit is set, the block SHALL pulse req_ready for exactly one winner, latch its address and owner, and enter CMD next cycle.
REQ-017 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; after reset the tie goes to requester 0.
REQ-018 A single active request SHALL be granted regardless of the round-robin pointer.
REQ-019 flash_csb SHALL fall in the cycle after the grant and stay low through all 64 bits.
REQ-020 Each SPI bit SHALL take 2*CLK_DIV cycles: CLK_DIV cycles flash_clk low, then CLK_DIV cycles high.
REQ-021 flash_io0 SHALL change only while flash_clk is low, and SHALL be stable at each rising edge.
REQ-022 Bits SHALL be sent MSB first: opcode 0x03, then address[23:0].
REQ-023 flash_io1 SHALL be sampled on the cycle flash_clk rises, MSB first within each byte.
REQ-024 Data byte n (n=0..3, in receive order) SHALL land in rdata[8n+7:8n] (little-endian word).
REQ-025 In DATA state flash_io0 SHALL drive 0.
REQ-026 After the 64th bit's high phase, the block SHALL, in the same cycle:
  - raise flash_csb;
  - drive flash_clk low;
  - pulse req_done[owner];
  - update rdata.
REQ-027 Latency from the req_ready cycle to the req_done cycle SHALL be exactly 1 + 128*CLK_DIV cycles.
REQ-028 GAP SHALL hold flash_csb high for 2 cycles, then return to IDLE; no grant is issued during GAP.
REQ-029 req_valid and address changes after the grant SHALL be ignored until the transaction completes.
REQ-030 The requester SHALL hold req_valid until req_ready; re-asserting req_valid immediately after req_ready is a new request.
REQ-031 req_ready and req_done SHALL never have both bits set, and SHALL never pulse in the same cycle.

Reset
REQ-032 On wb_rst_i=1 at a clock edge, the block SHALL set the following, from any state including mid-transfer:
  - state=IDLE;
  - flash_csb=1, flash_clk=0, flash_io0=0;
  - req_ready=0, req_done=0;
  - rdata=0;
  - round-robin pointer to favour requester 0.
REQ-033 A transaction interrupted by reset SHALL produce no req_done.

Verification
REQ-034 req_valid=01, addr 0x000100, flash model returns EF,BE,AD,DE -> io0 shows 03,00,01,00; req_done=01 257 cycles after req_ready; rdata=0xDEADBEEF.
REQ-035 req_valid=11 in the first cycle after reset -> req_ready=01 first, then 10 after GAP; flash_csb high for at least 2 cycles between transfers.
REQ-036 Both requests held continuously for 4 transactions -> grant order 0,1,0,1.
REQ-037 wb_rst_i pulsed during ADDR phase -> next cycle flash_csb=1, flash_clk=0, no req_done; a following req1 read completes normally.
REQ-038 CLK_DIV=1, single request -> flash_clk period 2 cycles; req_done 129 cycles after req_ready.
REQ-039 req_valid dropped and req0_addr changed mid-DATA -> the transfer completes using the original address; a single req_done is issued.
